mac_pe: RTL and testbench
=========================

Name: mac_pe

Overview:
- Output-stationary multiply-accumulate processing element for the TPU systolic array. It sits directly downstream of the 3-bit array multiplier mult3b and consumes its 6-bit product.
- Each accepted operand beat multiplies a_in by b_in through one mult3b instance and accumulates the product into a saturating accumulator.
- Operands are forwarded right/down to the neighbouring PE with one register stage.
- The final sum of each tile is held until a readout handshake completes.

Parameters:
- ACC_W, 10, accumulator/result width in bits. Must be >= 6. Default holds 16 x 49 = 784 without overflow.
- MAX_BEATS, 16, beats per tile after which the tile closes automatically even without in_last. Must be >= 1.
- CNT_W, 5, beat counter width. Must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sync_clr  input  1  synchronous abort/clear, highest priority after reset
- a_in  input  3  operand A from left neighbour
- b_in  input  3  operand B from top neighbour
- in_valid  input  1  operands valid
- in_last  input  1  qualifies the final beat of a tile (valid only with in_valid)
- in_ready  output  1  PE can accept a beat this cycle
- a_out  output  3  registered a_in to right neighbour
- b_out  output  3  registered b_in to lower neighbour
- out_valid  output  1  a_out/b_out carry a beat accepted last cycle
- result  output  ACC_W  accumulated tile sum
- result_valid  output  1  result holds a completed tile
- result_ready  input  1  downstream takes the result
- overflow  output  1  sticky: tile saturated
- beat_cnt  output  CNT_W  beats accepted in the current tile

Behaviour:
- Reset (rst_n low, async): state IDLE, a_out=0, b_out=0, out_valid=0, result=0, result_valid=0, overflow=0, beat_cnt=0.
- Derived signals:
  - in_ready = (state != HOLD).
  - accept = in_valid & in_ready.
  - product = mult3b(a_in, b_in), zero-extended to ACC_W.
- Forwarding:
  - On accept: a_out/b_out <= a_in/b_in and out_valid <= 1.
  - Otherwise out_valid <= 0 and a_out/b_out hold their values.
  - Latency is 1 cycle.
- State IDLE, on accept:
  - result <= product; beat_cnt <= 1; overflow <= 0.
  - If in_last or MAX_BEATS==1, go to HOLD; else go to ACCUM.
- State ACCUM, on accept:
  - sum = result + product, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1: result <= all-ones and overflow <= 1. Else result <= sum.
  - beat_cnt <= beat_cnt+1.
  - Go to HOLD if in_last or beat_cnt+1 == MAX_BEATS.
- ACCUM with no accept: all state holds. Gaps in in_valid are legal.
- State HOLD:
  - result_valid = 1 and in_ready = 0.
  - result, overflow and beat_cnt are stable.
  - On result_ready: go to IDLE, result <= 0, beat_cnt <= 0, result_valid <= 0. overflow stays readable until the next tile's first beat.
- result_valid is registered: high exactly the cycle after entering HOLD, low the cycle after the handshake.
- in_valid during HOLD is ignored: not accepted, not forwarded. Upstream must hold the beat.
- sync_clr, any state: next edge goes to IDLE with every output at its reset value.
  - Overrides a simultaneous accept or result handshake.
  - A beat presented that cycle is dropped (out_valid=0).
- Reset mid-tile: asynchronous return to the reset values. No partial result is presented.
- in_last with in_valid=0 has no effect.

Test Plan:
- Reset, then beats (3,5),(7,7),(2,6) with last on the third -> out_valid pulses the cycle after each beat with a_out/b_out echoed. result_valid rises the cycle after beat 3 with result=76, beat_cnt=3, overflow=0.
- 16 beats of (7,7), no in_last -> auto-close at beat 16: result=784, result_valid=1, in_ready=0. A 17th beat held on in_valid is not accepted until result_ready pulses, then starts a fresh tile: result=49, beat_cnt=1.
- ACC_W=8, MAX_BEATS=16: 6 beats of (7,7) with last -> result=255, overflow=1. The next tile's first beat (1,1) -> result=1, overflow=0.
- Beats (4,4),gap,gap,(3,2) with last -> gaps hold state and out_valid=0. result=22, beat_cnt=2.
- sync_clr asserted mid-tile, together with a valid beat, after 2 beats of (5,5) -> next cycle: result=0, beat_cnt=0, out_valid=0, state IDLE. A following beat (1,2) with last -> result=2.
- rst_n dropped asynchronously during HOLD, between clock edges -> result_valid, result and overflow go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mac_pe.sv
// Output-stationary multiply-accumulate PE for the systolic array: a 3x3 array
// multiplier feeds a saturating tile accumulator, and operands are forwarded right/down.

module mult3b (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [5:0] o_p
);
    logic [5:0] w_pp [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pp
            assign w_pp[gi] = 6'({3{i_b[gi]}} & i_a) << gi;
        end
    endgenerate

    assign o_p = w_pp[0] + w_pp[1] + w_pp[2];
endmodule

module mac_pe #(
    parameter int ACC_W     = 10,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic [2:0]       a_in,
    input  logic [2:0]       b_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [2:0]       a_out,
    output logic [2:0]       b_out,
    output logic             out_valid,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] beat_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_a_out;
    logic [2:0]         r_b_out;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_result;
    logic               r_result_valid;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_accept;
    logic [5:0]         w_product;
    logic [ACC_W-1:0]   w_product_ext;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_inc;

    mult3b u_mult (
        .i_a (a_in),
        .i_b (b_in),
        .o_p (w_product)
    );

    assign in_ready      = (r_state != S_HOLD);
    assign w_accept      = in_valid & in_ready;
    assign w_product_ext = ACC_W'(w_product);
    // One extra bit so a carry out of the accumulator flags saturation.
    assign w_sum         = {1'b0, r_result} + {1'b0, w_product_ext};
    assign w_cnt_inc     = r_beat_cnt + CNT_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (in_last || MAX_BEATS == 1) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && (in_last || w_cnt_inc == MAX_CNT)) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (result_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (sync_clr) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_out        <= '0;
            r_b_out        <= '0;
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
            r_beat_cnt     <= '0;
        end else if (sync_clr) begin
            r_a_out        <= '0;
            r_b_out        <= '0;
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_overflow     <= 1'b0;
            r_beat_cnt     <= '0;
        end else begin
            r_out_valid    <= w_accept;
            r_result_valid <= (w_state_next == S_HOLD);
            if (w_accept) begin
                r_a_out <= a_in;
                r_b_out <= b_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_result   <= w_product_ext;
                        r_beat_cnt <= CNT_W'(1);
                        r_overflow <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_cnt_inc;
                        if (w_sum[ACC_W]) begin
                            r_result   <= '1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_result <= w_sum[ACC_W-1:0];
                        end
                    end
                end
                S_HOLD: begin
                    // overflow is left alone so it stays readable after readout.
                    if (result_ready) begin
                        r_result   <= '0;
                        r_beat_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_out        = r_a_out;
    assign b_out        = r_b_out;
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign overflow     = r_overflow;
    assign beat_cnt     = r_beat_cnt;
endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: table of per-cycle vectors plus hand sequences for auto-close,
// saturation and async reset; forwarded operands are checked through a scoreboard queue.

module tb_mac_pe;
    logic       clk;
    logic       rst_n;
    logic       sync_clr;
    logic [2:0] a_in;
    logic [2:0] b_in;
    logic       in_valid;
    logic       in_last;
    logic       result_ready;

    logic       in_ready;
    logic [2:0] a_out;
    logic [2:0] b_out;
    logic       out_valid;
    logic [9:0] result;
    logic       result_valid;
    logic       overflow;
    logic [4:0] beat_cnt;

    logic       in_ready8;
    logic [2:0] a_out8;
    logic [2:0] b_out8;
    logic       out_valid8;
    logic [7:0] result8;
    logic       result_valid8;
    logic       overflow8;
    logic [4:0] beat_cnt8;

    int tests_run = 0;
    int tests_failed = 0;

    logic       drv_acc;
    logic [5:0] sb_q[$];

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       v;
        logic       last;
        logic       rr;
        logic       sc;
        logic       acc;
        int         res;
        int         cnt;
        int         rv;
        int         ovf;
        int         rdy;
    } vec_t;

    vec_t tbl[$];

    mac_pe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_clr     (sync_clr),
        .a_in         (a_in),
        .b_in         (b_in),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .a_out        (a_out),
        .b_out        (b_out),
        .out_valid    (out_valid),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow),
        .beat_cnt     (beat_cnt)
    );

    mac_pe #(.ACC_W(8), .MAX_BEATS(16), .CNT_W(5)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_clr     (sync_clr),
        .a_in         (a_in),
        .b_in         (b_in),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready8),
        .a_out        (a_out8),
        .b_out        (b_out8),
        .out_valid    (out_valid8),
        .result       (result8),
        .result_valid (result_valid8),
        .result_ready (result_ready),
        .overflow     (overflow8),
        .beat_cnt     (beat_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int a, input int b, input int v, input int last,
                          input int rr, input int sc, input int acc);
        a_in         = 3'(a);
        b_in         = 3'(b);
        in_valid     = 1'(v);
        in_last      = 1'(last);
        result_ready = 1'(rr);
        sync_clr     = 1'(sc);
        drv_acc      = 1'(acc);
    endtask

    // One clock: push the expected forward on accept, then compare what came out.
    task automatic tick();
        logic [5:0] exp_ab;
        if (drv_acc) sb_q.push_back({a_in, b_in});
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(drv_acc));
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("fwd_unexpected", 1, 0);
            end else begin
                exp_ab = sb_q.pop_front();
                check("a_out", int'(a_out), int'(exp_ab[5:3]));
                check("b_out", int'(b_out), int'(exp_ab[2:0]));
            end
        end
        $display("[TB] t=%0t a=%0d b=%0d v=%0d last=%0d rr=%0d sc=%0d -> res=%0d cnt=%0d rv=%0d ovf=%0d rdy=%0d res8=%0d ovf8=%0d",
                 $time, a_in, b_in, in_valid, in_last, result_ready, sync_clr,
                 result, beat_cnt, result_valid, overflow, in_ready, result8, overflow8);
    endtask

    task automatic add_vec(input int a, input int b, input int v, input int last,
                           input int rr, input int sc, input int acc, input int res,
                           input int cnt, input int rv, input int ovf, input int rdy);
        vec_t e;
        e.a = 3'(a); e.b = 3'(b); e.v = 1'(v); e.last = 1'(last);
        e.rr = 1'(rr); e.sc = 1'(sc); e.acc = 1'(acc);
        e.res = res; e.cnt = cnt; e.rv = rv; e.ovf = ovf; e.rdy = rdy;
        tbl.push_back(e);
    endtask

    initial begin
        //        a  b  v  l rr sc acc res cnt rv ovf rdy
        add_vec(3, 5, 1, 0, 0, 0, 1, 15, 1, 0, 0, 1);
        add_vec(7, 7, 1, 0, 0, 0, 1, 64, 2, 0, 0, 1);
        add_vec(2, 6, 1, 1, 0, 0, 1, 76, 3, 1, 0, 0);
        add_vec(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1);
        add_vec(4, 4, 1, 0, 0, 0, 1, 16, 1, 0, 0, 1);
        add_vec(7, 7, 0, 1, 0, 0, 0, 16, 1, 0, 0, 1);
        add_vec(5, 5, 0, 0, 0, 0, 0, 16, 1, 0, 0, 1);
        add_vec(3, 2, 1, 1, 0, 0, 1, 22, 2, 1, 0, 0);
        add_vec(1, 1, 1, 0, 0, 0, 0, 22, 2, 1, 0, 0);
        add_vec(1, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1);
        add_vec(5, 5, 1, 0, 0, 0, 1, 25, 1, 0, 0, 1);
        add_vec(5, 5, 1, 0, 0, 0, 1, 50, 2, 0, 0, 1);
        add_vec(5, 5, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        add_vec(1, 2, 1, 1, 0, 0, 1,  2, 1, 1, 0, 0);
        add_vec(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1);

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_result", int'(result), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_cnt", int'(beat_cnt), 0);
        check("rst_aout", int'(a_out), 0);
        check("rst_bout", int'(b_out), 0);
        check("rst_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            set_in(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].last, tbl[i].rr, tbl[i].sc, tbl[i].acc);
            tick();
            check("tbl_result", int'(result), tbl[i].res);
            check("tbl_result8", int'(result8), tbl[i].res);
            check("tbl_cnt", int'(beat_cnt), tbl[i].cnt);
            check("tbl_rv", int'(result_valid), tbl[i].rv);
            check("tbl_ovf", int'(overflow), tbl[i].ovf);
            check("tbl_ready", int'(in_ready), tbl[i].rdy);
        end

        // Auto-close after MAX_BEATS beats without in_last.
        for (int k = 1; k <= 16; k++) begin
            set_in(7, 7, 1, 0, 0, 0, 1);
            tick();
            check("auto_result", int'(result), 49 * k);
            check("auto_cnt", int'(beat_cnt), k);
        end
        check("auto_rv", int'(result_valid), 1);
        check("auto_ready", int'(in_ready), 0);
        check("auto_result8", int'(result8), 255);
        check("auto_ovf8", int'(overflow8), 1);
        for (int k = 0; k < 3; k++) begin
            set_in(7, 7, 1, 0, 0, 0, 0);
            tick();
            check("hold_result", int'(result), 784);
            check("hold_rv", int'(result_valid), 1);
        end
        set_in(7, 7, 1, 0, 1, 0, 0);
        tick();
        check("hs_rv", int'(result_valid), 0);
        check("hs_result", int'(result), 0);
        check("hs_ready", int'(in_ready), 1);
        check("hs_ovf8_kept", int'(overflow8), 1);
        set_in(7, 7, 1, 1, 0, 0, 1);
        tick();
        check("fresh_result", int'(result), 49);
        check("fresh_cnt", int'(beat_cnt), 1);
        check("fresh_ovf8", int'(overflow8), 0);
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();

        // Saturation on the 8-bit instance.
        for (int k = 1; k <= 6; k++) begin
            set_in(7, 7, 1, (k == 6) ? 1 : 0, 0, 0, 1);
            tick();
        end
        check("sat_result8", int'(result8), 255);
        check("sat_ovf8", int'(overflow8), 1);
        check("sat_rv8", int'(result_valid8), 1);
        check("sat_result", int'(result), 294);
        check("sat_ovf", int'(overflow), 0);
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();
        check("sat_hs_ovf8", int'(overflow8), 1);
        check("sat_hs_result8", int'(result8), 0);
        set_in(1, 1, 1, 1, 0, 0, 1);
        tick();
        check("next_result8", int'(result8), 1);
        check("next_ovf8", int'(overflow8), 0);
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();

        // Async reset while holding a saturated tile.
        for (int k = 1; k <= 6; k++) begin
            set_in(7, 7, 1, (k == 6) ? 1 : 0, 0, 0, 1);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("pre_arst_ovf8", int'(overflow8), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rv", int'(result_valid), 0);
        check("arst_result", int'(result), 0);
        check("arst_rv8", int'(result_valid8), 0);
        check("arst_result8", int'(result8), 0);
        check("arst_ovf8", int'(overflow8), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_arst_cnt", int'(beat_cnt), 0);
        check("post_arst_ready", int'(in_ready), 1);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
